// File: rtl/text_pkg.sv
// text_pkg: shared geometry constants and the clear-sequencer state encoding
// for the text-mode display path.
package text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/char_buffer.sv
// char_buffer: simple dual-port character RAM. One synchronous write port and
// one synchronous read port with a single registered read stage. The read
// register resets to a blank so the glyph path starts out showing spaces.
module char_buffer #(
  parameter int DEPTH  = text_pkg::COLS * text_pkg::ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);
  import text_pkg::*;

  logic [7:0] r_mem [0:DEPTH-1];
  logic [7:0] r_rdata;

  // Write port: storage itself is never reset; the clear sequencer blanks it.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: one-cycle registered read, no write-to-read bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= BLANK_CHAR;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/text_display_ctrl.sv
// text_display_ctrl: maps VGA pixel coordinates to character cells, reads the
// character buffer and feeds font_renderer, keeping sync/blank aligned with
// the 3-cycle glyph path. Also owns the buffer write port and a hardware
// clear-screen sequencer.
// Optional build macro: TEXT_DISPLAY_CURSOR_EN adds a blinking block cursor
// at cursor_addr driven by a vsync frame counter.
module text_display_ctrl #(
  parameter int COLS     = text_pkg::COLS,
  parameter int ROWS     = text_pkg::ROWS,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] cursor_addr,
  output logic              busy,
  output logic [7:0]        font_ascii,
  output logic [3:0]        font_row,
  output logic [2:0]        font_col,
  input  logic              font_pixel_on,
  output logic              pixel_on,
  output logic              video_on_out,
  output logic              hsync_out,
  output logic              vsync_out
);
  import text_pkg::*;

  localparam int CELLS = COLS * ROWS;
  localparam int CW_B  = $clog2(CHAR_W);
  localparam int CH_B  = $clog2(CHAR_H);

  // Widened by one bit so the bound is representable even when CELLS == 2^ADDR_W.
  localparam logic [ADDR_W:0]   CELLS_EXT = (ADDR_W + 1)'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  // ---------------------------------------------------------------------------
  // S0: cell decode and read address
  // ---------------------------------------------------------------------------
  logic [9-CW_B:0]   w_cell_col;
  logic [9-CH_B:0]   w_cell_row;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [7:0]        w_rd_data;

  assign w_cell_col = pix_x[9:CW_B];
  assign w_cell_row = pix_y[9:CH_B];
  assign w_in_range = (pix_x < 10'(H_ACTIVE)) && (pix_y < 10'(V_ACTIVE));

  // Outside the visible window the read address parks at cell 0 so the RAM
  // never sees an index beyond the screen.
  assign w_rd_addr = (w_in_range && video_on)
                   ? (ADDR_W'(w_cell_row) * ADDR_W'(COLS) + ADDR_W'(w_cell_col))
                   : '0;

  // ---------------------------------------------------------------------------
  // Clear sequencer and write-port arbitration
  // ---------------------------------------------------------------------------
  clr_state_t        r_state;
  clr_state_t        w_state_next;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_next;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;

  // State register: reset launches a full-screen clear from cell 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  // Next-state and write-port mux: the sequencer owns the port while clearing,
  // so user writes and repeated clear requests are simply dropped then.
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_we           = 1'b0;
    w_waddr        = wr_addr;
    w_wdata        = wr_data;
    case (r_state)
      IDLE: begin
        w_we = wr_en && ({1'b0, wr_addr} < CELLS_EXT);
        if (clr_req) begin
          w_state_next   = CLEAR;
          w_clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        w_wdata = BLANK_CHAR;
        if (r_clr_cnt == LAST_CELL) begin
          w_state_next = IDLE;
        end else begin
          w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign busy = (r_state == CLEAR);

  char_buffer #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W)
  ) u_char_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // ---------------------------------------------------------------------------
  // S1..S3 alignment pipeline
  // ---------------------------------------------------------------------------
  logic [CH_B-1:0] r_row_d1;
  logic [CW_B-1:0] r_col_d1;
  logic [CW_B-1:0] r_col_d2;
  logic            r_vis_d1;
  logic            r_vis_d2;
  logic            r_rng_d1;
  logic            r_rng_d2;
  logic            r_pix_on;
  logic [8:0]      r_sync_sr;
  logic            w_cursor_hit;

  // Glyph coordinates and gating flags follow the RAM and font ROM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_d1 <= '0;
      r_col_d1 <= '0;
      r_col_d2 <= '0;
      r_vis_d1 <= 1'b0;
      r_vis_d2 <= 1'b0;
      r_rng_d1 <= 1'b0;
      r_rng_d2 <= 1'b0;
    end else begin
      r_row_d1 <= pix_y[CH_B-1:0];
      r_col_d1 <= pix_x[CW_B-1:0];
      r_col_d2 <= r_col_d1;
      r_vis_d1 <= video_on;
      r_vis_d2 <= r_vis_d1;
      r_rng_d1 <= w_in_range;
      r_rng_d2 <= r_rng_d1;
    end
  end

  // Three-stage shift of {video_on, hsync, vsync} to match pixel_on latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_sr <= '0;
    end else begin
      r_sync_sr <= {r_sync_sr[5:0], video_on, hsync_in, vsync_in};
    end
  end

`ifdef TEXT_DISPLAY_CURSOR_EN
  logic [5:0]        r_frame_cnt;
  logic              r_vsync_prev;
  logic [ADDR_W-1:0] r_addr_d1;
  logic [ADDR_W-1:0] r_addr_d2;

  // Frame counter advances on each vsync rising edge; bit 5 is the blink phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt  <= '0;
      r_vsync_prev <= 1'b0;
    end else begin
      r_vsync_prev <= vsync_in;
      if (vsync_in && !r_vsync_prev) begin
        r_frame_cnt <= r_frame_cnt + 6'd1;
      end
    end
  end

  // Carry the cell address alongside the glyph so the cursor compare lines up at S3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_d1 <= '0;
      r_addr_d2 <= '0;
    end else begin
      r_addr_d1 <= w_rd_addr;
      r_addr_d2 <= r_addr_d1;
    end
  end

  assign w_cursor_hit = r_frame_cnt[5] && (r_addr_d2 == cursor_addr);
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^cursor_addr;
  assign w_cursor_hit    = 1'b0;
`endif

  // S3: final text pixel; the cursor inverts only inside the visible window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_on <= 1'b0;
    end else begin
      r_pix_on <= (font_pixel_on ^ w_cursor_hit) & r_vis_d2 & r_rng_d2;
    end
  end

  assign font_ascii   = w_rd_data;
  assign font_row     = r_row_d1;
  assign font_col     = r_col_d2;
  assign pixel_on     = r_pix_on;
  assign video_on_out = r_sync_sr[8];
  assign hsync_out    = r_sync_sr[7];
  assign vsync_out    = r_sync_sr[6];

endmodule

// File: tb/tb_text_display_ctrl.sv
// tb_text_display_ctrl: directed self-checking bench for text_display_ctrl,
// with a small synchronous font ROM model standing in for font_renderer.
`timescale 1ns/1ps
module tb_text_display_ctrl;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        pix_x;
  logic [9:0]        pix_y;
  logic              video_on;
  logic              hsync_in;
  logic              vsync_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              clr_req;
  logic [ADDR_W-1:0] cursor_addr;
  logic              busy;
  logic [7:0]        font_ascii;
  logic [3:0]        font_row;
  logic [2:0]        font_col;
  logic              font_pixel_on;
  logic              pixel_on;
  logic              video_on_out;
  logic              hsync_out;
  logic              vsync_out;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef TEXT_DISPLAY_CURSOR_EN
  localparam logic CURSOR_EXP = 1'b1;
`else
  localparam logic CURSOR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  text_display_ctrl #(
    .COLS     (80),
    .ROWS     (30),
    .H_ACTIVE (640),
    .V_ACTIVE (480),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .video_on      (video_on),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .clr_req       (clr_req),
    .cursor_addr   (cursor_addr),
    .busy          (busy),
    .font_ascii    (font_ascii),
    .font_row      (font_row),
    .font_col      (font_col),
    .font_pixel_on (font_pixel_on),
    .pixel_on      (pixel_on),
    .video_on_out  (video_on_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out)
  );

  // Font ROM model: space is empty, 'A' has a fixed bitmap, anything else is solid.
  function automatic logic [7:0] glyph_row(input logic [7:0] code, input logic [3:0] row);
    if (code == 8'h20) return 8'h00;
    if (code == 8'h41) begin
      case (row)
        4'd2:                      return 8'h10;
        4'd3:                      return 8'h6C;
        4'd6:                      return 8'hFE;
        4'd4, 4'd5, 4'd7, 4'd8,
        4'd9, 4'd10:               return 8'hC6;
        default:                   return 8'h00;
      endcase
    end
    return 8'hFF;
  endfunction

  logic [7:0] r_glyph;
  always @(posedge clk) r_glyph <= glyph_row(font_ascii, font_row);
  assign font_pixel_on = r_glyph[3'd7 - font_col];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_pix(input int x, input int y, input logic vo);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = vo;
  endtask

  task automatic read_cell(input int addr, output logic [7:0] code);
    set_pix((addr % 80) * 8, (addr / 80) * 16, 1'b1);
    tick();
    code = font_ascii;
  endtask

  task automatic write_cell(input int addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] code;
    int n;
    logic hs_hist [0:23];
    logic vs_hist [0:23];
    logic vo_hist [0:23];

    rst = 1'b1; pix_x = '0; pix_y = '0; video_on = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; clr_req = 1'b0; cursor_addr = '0;

    // Reset state and reset-triggered clear length
    tick();
    rst = 1'b0;
    check_eq("rst_busy", busy, 1);
    check_eq("rst_font_ascii", font_ascii, 8'h20);
    check_eq("rst_font_row", font_row, 0);
    check_eq("rst_font_col", font_col, 0);
    check_eq("rst_pixel_on", pixel_on, 0);
    check_eq("rst_sync_out", {video_on_out, hsync_out, vsync_out}, 0);
    count_busy(n);
    check_eq("rst_clear_cycles", n, 2400);
    read_cell(0, code);    check_eq("blank_cell0", code, 8'h20);
    read_cell(1234, code); check_eq("blank_cell1234", code, 8'h20);
    read_cell(2399, code); check_eq("blank_cell2399", code, 8'h20);

    // Writes, including the last valid cell and one past the end
    set_pix(0, 0, 1'b0);
    write_cell(162, 8'h41);
    write_cell(0, 8'h23);
    write_cell(2399, 8'h5A);
    write_cell(2400, 8'h55);

    // Cell mapping and pipeline latency for 'A' at (17,35)
    set_pix(17, 35, 1'b1);
    tick();
    check_eq("map_font_ascii", font_ascii, 8'h41);
    check_eq("map_font_row", font_row, 3);
    tick();
    check_eq("map_font_col", font_col, 1);
    tick();
    check_eq("map_pixel_on_c1", pixel_on, 1);
    set_pix(16, 35, 1'b1);
    tick_n(3);
    check_eq("map_pixel_on_c0", pixel_on, 0);

    // Range and blanking gates: address parks at cell 0, pixel forced low
    set_pix(700, 35, 1'b1);
    tick();
    check_eq("range_addr0", font_ascii, 8'h23);
    tick_n(2);
    check_eq("range_pixel_off", pixel_on, 0);
    set_pix(17, 35, 1'b0);
    tick();
    check_eq("blank_addr0", font_ascii, 8'h23);
    tick_n(2);
    check_eq("blank_pixel_off", pixel_on, 0);
    set_pix(639, 479, 1'b1);
    tick();
    check_eq("edge_ascii", font_ascii, 8'h5A);
    tick_n(2);
    check_eq("edge_pixel_on", pixel_on, 1);
    set_pix(639, 480, 1'b1);
    tick_n(3);
    check_eq("below_pixel_off", pixel_on, 0);
    read_cell(0, code);    check_eq("bound_cell0", code, 8'h23);
    read_cell(2399, code); check_eq("bound_cell2399", code, 8'h5A);

    // Sync/blank alignment: outputs equal inputs from three cycles earlier
    for (int i = 0; i < 24; i++) begin
      hs_hist[i] = (i % 5) < 2;
      vs_hist[i] = (i % 7) == 3;
      vo_hist[i] = (i % 3) != 0;
      hsync_in = hs_hist[i];
      vsync_in = vs_hist[i];
      video_on = vo_hist[i];
      pix_x    = 10'((i * 37) % 640);
      pix_y    = 10'((i * 53) % 480);
      tick();
      if (i >= 2) begin
        check_eq($sformatf("align_hs_%0d", i), hsync_out, hs_hist[i-2]);
        check_eq($sformatf("align_vs_%0d", i), vsync_out, vs_hist[i-2]);
        check_eq($sformatf("align_vo_%0d", i), video_on_out, vo_hist[i-2]);
      end
    end
    hsync_in = 1'b0; vsync_in = 1'b0;

    // Clear with a simultaneous write; mid-clear write and clr_req are dropped
    set_pix(632, 464, 1'b1);
    wr_en = 1'b1; wr_addr = 12'd5; wr_data = 8'h42; clr_req = 1'b1;
    tick();
    wr_en = 1'b0; clr_req = 1'b0;
    check_eq("clr_busy_start", busy, 1);
    n = 0;
    while (busy && n < 3000) begin
      if (n == 100) begin
        wr_en = 1'b1; wr_addr = 12'd7; wr_data = 8'h46; clr_req = 1'b1;
      end else begin
        wr_en = 1'b0; clr_req = 1'b0;
      end
      tick();
      n++;
      if (n == 10) check_eq("clr_partial_read", font_ascii, 8'h5A);
    end
    wr_en = 1'b0; clr_req = 1'b0;
    check_eq("clr_cycles", n, 2400);
    read_cell(5, code);    check_eq("clr_cell5", code, 8'h20);
    read_cell(7, code);    check_eq("clr_cell7_drop", code, 8'h20);
    read_cell(0, code);    check_eq("clr_cell0", code, 8'h20);
    read_cell(162, code);  check_eq("clr_cell162", code, 8'h20);
    read_cell(2399, code); check_eq("clr_cell2399", code, 8'h20);

    // Reset in the middle of a clear restarts the full sequence
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick_n(1000);
    check_eq("midclr_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midclr_rst_busy", busy, 1);
    count_busy(n);
    check_eq("midclr_restart_cycles", n, 2400);

    // Cursor: 32 vsync rising edges set the blink phase
    cursor_addr = '0;
    for (int f = 0; f < 32; f++) begin
      vsync_in = 1'b1; tick();
      vsync_in = 1'b0; tick();
    end
    set_pix(0, 0, 1'b1);  tick_n(3); check_eq("cursor_0_0", pixel_on, CURSOR_EXP);
    set_pix(7, 15, 1'b1); tick_n(3); check_eq("cursor_7_15", pixel_on, CURSOR_EXP);
    set_pix(3, 8, 1'b1);  tick_n(3); check_eq("cursor_3_8", pixel_on, CURSOR_EXP);
    set_pix(8, 0, 1'b1);  tick_n(3); check_eq("cursor_cell1_off", pixel_on, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
